lc3_controller: RTL and testbench
=================================

LC3_CONTROLLER -- requirements
Module: lc3_controller

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 complete_instr  input  1  instruction memory returned valid data this cycle.
REQ-005 complete_data  input  1  data memory access completed this cycle.
REQ-006 IR  input  16  instruction in decode stage.
REQ-007 IR_Exec  input  16  instruction in execute stage.
REQ-008 psr  input  3  current N/Z/P condition codes.
REQ-009 enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback  output  1 each  pipeline stage enables.
REQ-010 br_taken  output  1  control transfer taken.
REQ-011 bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2  output  1 each  operand forwarding selects.
REQ-012 mem_state  output  2  memory FSM state: 3 IDLE, 0 READ, 1 READ_IND, 2 WRITE.

Function
REQ-013 Opcodes (IR[15:12]): ALU = ADD 0001, AND 0101, NOT 1001; CTRL = BR 0000, JMP 1100; LOAD = LD 0010, LDR 0110, LDI 1010; STORE = ST 0011, STR 0111, STI 1011; LEA 1110 is ALU-class for bypass.
REQ-014 Pipeline fill: a 4-bit fill register SHALL shift in 1 each cycle after reset. enable_updatePC and enable_fetch SHALL be active from cycle 1, enable_decode from cycle 2, enable_execute from cycle 3 and enable_writeback from cycle 4, subject to the stalls below.
REQ-015 exe_done SHALL be a register holding the previous cycle's enable_execute.
REQ-016 Memory FSM transitions from IDLE, taken when exe_done=1:
  - LD/LDR -> READ.
  - LDI/STI -> READ_IND.
  - ST/STR -> WRITE.
  - otherwise stay in IDLE.
REQ-017 Memory FSM transitions on complete_data=1:
  - READ_IND -> READ for LDI, READ_IND -> WRITE for STI.
  - READ -> IDLE, WRITE -> IDLE.
  - Without complete_data the FSM SHALL hold its state indefinitely.
REQ-018 While mem_state != IDLE, enable_updatePC, enable_fetch, enable_decode and enable_execute SHALL be 0.
REQ-019 enable_writeback SHALL be 1 for exactly the one cycle in which READ exits to IDLE; it SHALL be 0 otherwise during a memory access.
REQ-020 Control stall: when enable_decode=1 and IR is CTRL, a 2-bit ctrl_cnt SHALL load 3.
  - ctrl_cnt SHALL decrement each cycle while nonzero and mem_state=IDLE.
  - While ctrl_cnt != 0: enable_updatePC, enable_fetch and enable_decode SHALL be 0.
  - enable_execute SHALL be 1 only at ctrl_cnt=3.
REQ-021 br_taken SHALL be asserted combinationally when ctrl_cnt=2 and either IR_Exec is JMP, or IR_Exec is BR with |(IR_Exec[11:9] & psr)=1; it SHALL be 0 otherwise.
REQ-022 Fetch stall: when complete_instr=0, enable_updatePC and enable_fetch SHALL be 0; the other enables are unaffected.
REQ-023 Stall priority SHALL be: reset > memory stall > control stall > fetch stall.
REQ-024 Bypass logic is combinational and is forced to 0 when exe_done=0:
  - bypass_alu_1 = IR_Exec ALU-class & IR_Exec[11:9]==IR[8:6] & IR is ALU or STORE.
  - bypass_alu_2 = IR_Exec ALU-class & IR_Exec[11:9]==IR[2:0] & IR is ADD/AND with IR[5]=0.
  - bypass_mem_1 and bypass_mem_2 use the same equations with IR_Exec LOAD-class.
REQ-025 A CTRL instruction in decode during a memory stall SHALL NOT load ctrl_cnt until enable_decode=1.

Reset
REQ-026 On reset assertion, independent of the clock: mem_state=3, ctrl_cnt=0, fill register=0, exe_done=0.
REQ-027 While reset is high, all enables, br_taken and all bypass outputs SHALL be 0.
REQ-028 Reset asserted mid-access (mem_state != 3) SHALL abort the access. After release, the pipeline SHALL refill per REQ-014.

Verification
REQ-029 Fill: release reset, IR=IR_Exec=ADD, complete_instr=1 -> enables rise in order updatePC/fetch at cycle 1, decode at 2, execute at 3, writeback at 4.
REQ-030 LDI: IR_Exec=0xA5FF, exe_done=1 -> mem_state 3->1. Then complete_data -> 0. Then complete_data -> 3 with a one-cycle enable_writeback pulse. Fetch/decode/execute stay 0 throughout.
REQ-031 Branch: IR=0x0E05 (BRnzp) with enable_decode=1, psr=3'b010 -> updatePC/fetch/decode low for 3 cycles. br_taken=1 at ctrl_cnt=2. BRn (0x0805) with psr=3'b010 -> br_taken=0.
REQ-032 Bypass: IR_Exec=0x1261 (ADD R1,R1,#1), IR=0x1441 (ADD R2,R1,R1), exe_done=1 -> bypass_alu_1=bypass_alu_2=1. With IR_Exec=0x2200 (LD R1) -> bypass_mem_1=bypass_mem_2=1.
REQ-033 Reset mid-STI: assert reset while mem_state=2 -> mem_state=3 and all outputs 0 immediately, with no clock edge required.
REQ-034 Simultaneous events: complete_instr=0 while ctrl_cnt=2 -> control stall outputs unchanged. complete_data=0 held 10 cycles in READ -> mem_state stays 0 and all enables stay 0.

Source files
------------

// File: rtl/lc3_controller.sv
// LC-3 pipeline controller: stage enables, the memory-access FSM,
// the branch/jump stall counter and the operand-forwarding selects.
module lc3_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  psr,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2,
    output logic [1:0]  mem_state
);

    typedef enum logic [1:0] {
        MEM_READ     = 2'd0,
        MEM_READ_IND = 2'd1,
        MEM_WRITE    = 2'd2,
        MEM_IDLE     = 2'd3
    } mem_state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic logic is_alu_class(input logic [3:0] op);
        return is_alu(op) || (op == OP_LEA);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_ctrl(input logic [3:0] op);
        return (op == OP_BR) || (op == OP_JMP);
    endfunction

    mem_state_t  state_q, state_d;
    logic [3:0]  fill_q;
    logic [1:0]  ctrl_cnt_q, ctrl_cnt_d;
    logic        exe_done_q;

    logic [3:0]  op_dec, op_exe;
    assign op_dec = IR[15:12];
    assign op_exe = IR_Exec[15:12];

    logic unused_ir_bits;
    assign unused_ir_bits = ^{IR[11:9], IR[4:3], IR_Exec[8:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= MEM_IDLE;
            fill_q     <= 4'b0000;
            ctrl_cnt_q <= 2'd0;
            exe_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= {fill_q[2:0], 1'b1};
            ctrl_cnt_q <= ctrl_cnt_d;
            exe_done_q <= enable_execute;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: begin
                if (exe_done_q) begin
                    if ((op_exe == OP_LD) || (op_exe == OP_LDR))       state_d = MEM_READ;
                    else if ((op_exe == OP_LDI) || (op_exe == OP_STI)) state_d = MEM_READ_IND;
                    else if ((op_exe == OP_ST) || (op_exe == OP_STR))  state_d = MEM_WRITE;
                    else                                               state_d = MEM_IDLE;
                end
            end
            // The indirect pointer fetch is shared; the opcode picks the second access.
            MEM_READ_IND: begin
                if (complete_data) state_d = (op_exe == OP_LDI) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                if (complete_data) state_d = MEM_IDLE;
            end
            MEM_WRITE: begin
                if (complete_data) state_d = MEM_IDLE;
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // Stall priority: reset, then memory access, then control transfer, then fetch.
    always_comb begin
        enable_updatePC  = fill_q[0];
        enable_fetch     = fill_q[0];
        enable_decode    = fill_q[1];
        enable_execute   = fill_q[2];
        enable_writeback = fill_q[3];
        if (reset) begin
            enable_updatePC  = 1'b0;
            enable_fetch     = 1'b0;
            enable_decode    = 1'b0;
            enable_execute   = 1'b0;
            enable_writeback = 1'b0;
        end else if (state_q != MEM_IDLE) begin
            enable_updatePC  = 1'b0;
            enable_fetch     = 1'b0;
            enable_decode    = 1'b0;
            enable_execute   = 1'b0;
            enable_writeback = (state_q == MEM_READ) && complete_data;
        end else if (ctrl_cnt_q != 2'd0) begin
            enable_updatePC  = 1'b0;
            enable_fetch     = 1'b0;
            enable_decode    = 1'b0;
            enable_execute   = (ctrl_cnt_q == 2'd3);
        end else if (!complete_instr) begin
            enable_updatePC  = 1'b0;
            enable_fetch     = 1'b0;
        end
    end

    // enable_decode is already low during a memory stall, so a CTRL op waits for it.
    always_comb begin
        ctrl_cnt_d = ctrl_cnt_q;
        if (enable_decode && is_ctrl(op_dec))
            ctrl_cnt_d = 2'd3;
        else if ((ctrl_cnt_q != 2'd0) && (state_q == MEM_IDLE))
            ctrl_cnt_d = ctrl_cnt_q - 2'd1;
    end

    always_comb begin
        br_taken = 1'b0;
        if (!reset && (ctrl_cnt_q == 2'd2)) begin
            if (op_exe == OP_JMP)
                br_taken = 1'b1;
            else if ((op_exe == OP_BR) && (|(IR_Exec[11:9] & psr)))
                br_taken = 1'b1;
        end
    end

    logic fwd_ok, match_1, match_2, src_1_used, src_2_used;
    assign fwd_ok     = exe_done_q && !reset;
    assign match_1    = (IR_Exec[11:9] == IR[8:6]);
    assign match_2    = (IR_Exec[11:9] == IR[2:0]);
    assign src_1_used = is_alu(op_dec) || is_store(op_dec);
    assign src_2_used = ((op_dec == OP_ADD) || (op_dec == OP_AND)) && !IR[5];

    assign bypass_alu_1 = fwd_ok && is_alu_class(op_exe) && match_1 && src_1_used;
    assign bypass_alu_2 = fwd_ok && is_alu_class(op_exe) && match_2 && src_2_used;
    assign bypass_mem_1 = fwd_ok && is_load(op_exe) && match_1 && src_1_used;
    assign bypass_mem_2 = fwd_ok && is_load(op_exe) && match_2 && src_2_used;

    assign mem_state = state_q;

endmodule

// File: tb/tb_lc3_controller.sv
// Directed bench for lc3_controller: fill, memory FSM, branch stall,
// forwarding selects and asynchronous reset during an access.
module tb_lc3_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        complete_instr, complete_data;
    logic [15:0] IR, IR_Exec;
    logic [2:0]  psr;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
    logic        br_taken;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [1:0]  mem_state;

    int n_tests = 0;
    int n_fail  = 0;

    lc3_controller dut (
        .clock            (clock),
        .reset            (reset),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .IR               (IR),
        .IR_Exec          (IR_Exec),
        .psr              (psr),
        .enable_updatePC  (enable_updatePC),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .br_taken         (br_taken),
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2),
        .bypass_mem_1     (bypass_mem_1),
        .bypass_mem_2     (bypass_mem_2),
        .mem_state        (mem_state)
    );

    always #5 clock = ~clock;

    logic [4:0] en;
    logic [3:0] byp;
    assign en  = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback};
    assign byp = {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [4:0] fill_exp [4];

    initial begin
        fill_exp[0] = 5'b11000;
        fill_exp[1] = 5'b11100;
        fill_exp[2] = 5'b11110;
        fill_exp[3] = 5'b11111;

        reset = 1'b1; complete_instr = 1'b1; complete_data = 1'b0;
        IR = 16'h1000; IR_Exec = 16'h1000; psr = 3'b000;
        #3;
        check("rst_en",  16'(en), 16'h0);
        check("rst_mem", 16'(mem_state), 16'h3);
        check("rst_byp", 16'(byp), 16'h0);
        check("rst_br",  16'(br_taken), 16'h0);
        #9 reset = 1'b0;

        // pipeline fill
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("fill_c%0d", i + 1), 16'(en), 16'(fill_exp[i]));
        end

        // forwarding selects, all within one cycle
        IR_Exec = 16'h1261; IR = 16'h1441; #1;
        check("byp_alu_both", 16'(byp), 16'h0C);
        IR = 16'h1461; #1;
        check("byp_alu_imm", 16'(byp), 16'h08);
        IR = 16'h1441; IR_Exec = 16'h2200; #1;
        check("byp_mem_both", 16'(byp), 16'h03);
        IR_Exec = 16'hE200; #1;
        check("byp_lea", 16'(byp), 16'h0C);
        IR_Exec = 16'hA5FF; IR = 16'h1000;

        // LDI: IDLE -> READ_IND -> READ -> IDLE
        tick();
        check("ldi_mem_ind", 16'(mem_state), 16'h1);
        check("ldi_en_ind",  16'(en), 16'h0);
        complete_data = 1'b1; #1;
        check("ldi_en_ind_done", 16'(en), 16'h0);
        tick();
        complete_data = 1'b0; #1;
        check("ldi_mem_read", 16'(mem_state), 16'h0);
        check("ldi_en_read",  16'(en), 16'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("read_hold_mem%0d", i), 16'(mem_state), 16'h0);
            check($sformatf("read_hold_en%0d", i),  16'(en), 16'h0);
        end
        complete_data = 1'b1; #1;
        check("ldi_wb_pulse", 16'(en), 16'h01);
        tick();
        complete_data = 1'b0; IR_Exec = 16'h1000; #1;
        check("ldi_mem_idle", 16'(mem_state), 16'h3);
        check("ldi_en_after", 16'(en), 16'h1F);

        // BRnzp taken with Z set
        IR = 16'h0E05; psr = 3'b010; #1;
        check("br_decode", 16'(en), 16'h1F);
        tick();
        IR = 16'h1000; IR_Exec = 16'h0E05; #1;
        check("br_c3_en", 16'(en), 16'h03);
        check("br_c3_br", 16'(br_taken), 16'h0);
        tick();
        check("br_c2_en", 16'(en), 16'h01);
        check("br_c2_br", 16'(br_taken), 16'h1);
        complete_instr = 1'b0; #1;
        check("br_c2_nofetch_en", 16'(en), 16'h01);
        check("br_c2_nofetch_br", 16'(br_taken), 16'h1);
        complete_instr = 1'b1;
        tick();
        check("br_c1_en", 16'(en), 16'h01);
        check("br_c1_br", 16'(br_taken), 16'h0);
        tick();
        check("br_c0_en", 16'(en), 16'h1F);

        // BRn not taken with Z set
        IR = 16'h0805;
        tick();
        IR = 16'h1000; IR_Exec = 16'h0805;
        tick();
        check("brn_c2_br", 16'(br_taken), 16'h0);
        check("brn_c2_en", 16'(en), 16'h01);
        tick();
        tick();
        check("brn_c0_en", 16'(en), 16'h1F);

        // JMP taken regardless of flags
        IR = 16'hC1C0; psr = 3'b000;
        tick();
        IR = 16'h1000; IR_Exec = 16'hC1C0;
        tick();
        check("jmp_c2_br", 16'(br_taken), 16'h1);
        tick();
        tick();
        IR_Exec = 16'h1000;
        tick();

        // STI, then reset in WRITE
        IR_Exec = 16'hB5FF;
        tick();
        check("sti_mem_ind", 16'(mem_state), 16'h1);
        complete_data = 1'b1;
        tick();
        complete_data = 1'b0; #1;
        check("sti_mem_write", 16'(mem_state), 16'h2);
        check("sti_en_write",  16'(en), 16'h0);
        #2 reset = 1'b1; #1;
        check("async_rst_mem", 16'(mem_state), 16'h3);
        check("async_rst_en",  16'(en), 16'h0);
        check("async_rst_br",  16'(br_taken), 16'h0);
        check("async_rst_byp", 16'(byp), 16'h0);
        IR_Exec = 16'h1000;
        tick();
        check("rst_hold_en", 16'(en), 16'h0);
        #3 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("refill_c%0d", i + 1), 16'(en), 16'(fill_exp[i]));
        end

        // ST: IDLE -> WRITE -> IDLE without a writeback pulse
        IR_Exec = 16'h3200;
        tick();
        check("st_mem_write", 16'(mem_state), 16'h2);
        complete_data = 1'b1; #1;
        check("st_no_wb", 16'(en), 16'h0);
        tick();
        complete_data = 1'b0; IR_Exec = 16'h1000; #1;
        check("st_mem_idle", 16'(mem_state), 16'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
